// File: rtl/eth_mii_rx_framer.sv
// MII receive framer: preamble/SFD strip, nibble-to-word packing, length and FCS check, output FIFO.
// Optional CRC-32 FCS check is built when ETH_RX_CRC_CHECK_EN is defined.
module eth_mii_rx_framer #(
    parameter int DATA_BYTES = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int MIN_FRAME  = 64,
    parameter int MAX_FRAME  = 1518
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              mii_rxd,
    input  logic                    mii_rx_dv,
    input  logic                    mii_rx_er,
    output logic [8*DATA_BYTES-1:0] m_data,
    output logic [DATA_BYTES-1:0]   m_keep,
    output logic                    m_last,
    output logic                    m_err,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [15:0]             drop_cnt
);
    localparam int DW = 8 * DATA_BYTES;
    localparam int EW = DW + DATA_BYTES + 2;
    localparam int LW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   OCC_LIM   = (AW+1)'(FIFO_DEPTH - 1);
    localparam logic [AW:0]   OCC_MAX   = (AW+1)'(FIFO_DEPTH);
    localparam logic [10:0]   MIN_L     = 11'(MIN_FRAME);
    localparam logic [10:0]   MAX_L     = 11'(MAX_FRAME);
    localparam logic [LW-1:0] LAST_LANE = LW'(DATA_BYTES - 1);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      rxd_q, lo_q, lo_d;
    logic            dv_q, dv_prev_q, er_q;
    logic            seen5_q, seen5_d;
    logic            half_q, half_d, full_q, full_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [DW-1:0]   word_q, word_d;
    logic [10:0]     cnt_q, cnt_d;
    logic            err_q, err_d, ovf_q, ovf_d;
    logic [15:0]     drop_q, drop_d;
    logic [7:0]      byte_v;
    logic            len_bad, crc_bad;

    logic            push, pop, wr;
    logic [DW-1:0]   push_data;
    logic [DATA_BYTES-1:0] push_keep;
    logic            push_last, push_err;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wp_q, rp_q;
    logic [AW:0]     occ_q;

`ifdef ETH_RX_CRC_CHECK_EN
    logic [31:0] crc_q, crc_d;

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign crc_bad = (crc_q != 32'hDEBB20E3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) crc_q <= '1;
        else        crc_q <= crc_d;
    end
`else
    assign crc_bad = 1'b0;
`endif

    // Previous-dv resets high so a frame in flight at reset release is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_q     <= '0;
            dv_q      <= 1'b1;
            dv_prev_q <= 1'b1;
            er_q      <= 1'b0;
        end else begin
            rxd_q     <= mii_rxd;
            dv_q      <= mii_rx_dv;
            dv_prev_q <= dv_q;
            er_q      <= mii_rx_er;
        end
    end

    assign byte_v  = {rxd_q, lo_q};
    assign len_bad = (cnt_q < MIN_L) || (cnt_q > MAX_L);

    // A completed word is held one nibble so a frame ending on a word boundary tags it last.
    always_comb begin
        state_d   = state_q;
        seen5_d   = seen5_q;
        lo_d      = lo_q;
        half_d    = half_q;
        full_d    = full_q;
        lane_d    = lane_q;
        word_d    = word_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        ovf_d     = ovf_q;
        drop_d    = drop_q;
`ifdef ETH_RX_CRC_CHECK_EN
        crc_d     = crc_q;
`endif
        push      = 1'b0;
        push_data = word_q;
        push_keep = '0;
        push_last = 1'b0;
        push_err  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dv_q && !dv_prev_q) begin
                    if (occ_q >= OCC_LIM) begin
                        state_d = DROP;
                        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                    end else begin
                        state_d = PREAMBLE;
                        seen5_d = (rxd_q == 4'h5);
                    end
                end
            end
            PREAMBLE: begin
                if (!dv_q) begin
                    state_d = IDLE;
                end else if (rxd_q == 4'h5) begin
                    seen5_d = 1'b1;
                end else if (rxd_q == 4'hD && seen5_q) begin
                    state_d = DATA;
                    half_d  = 1'b0;
                    full_d  = 1'b0;
                    lane_d  = '0;
                    word_d  = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    ovf_d   = 1'b0;
`ifdef ETH_RX_CRC_CHECK_EN
                    crc_d   = '1;
`endif
                end else begin
                    state_d = DROP;
                end
            end
            DATA: begin
                if (!dv_q) begin
                    push      = 1'b1;
                    push_data = word_q;
                    push_last = 1'b1;
                    for (int i = 0; i < DATA_BYTES; i++)
                        push_keep[i] = full_q | (i < int'(lane_q));
                    push_err  = err_q | ovf_q | half_q | len_bad | crc_bad;
                    full_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    if (er_q) err_d = 1'b1;
                    if (full_q) begin
                        full_d = 1'b0;
                        word_d = '0;
                        if (occ_q < OCC_LIM) begin
                            push      = 1'b1;
                            push_data = word_q;
                            push_keep = '1;
                        end else begin
                            ovf_d = 1'b1;
                            err_d = 1'b1;
                        end
                    end
                    if (!half_q) begin
                        lo_d   = rxd_q;
                        half_d = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        if (cnt_q != 11'h7FF) cnt_d = cnt_q + 11'd1;
`ifdef ETH_RX_CRC_CHECK_EN
                        crc_d = crc_next(crc_q, byte_v);
`endif
                        if (cnt_q >= MAX_L) begin
                            err_d = 1'b1;
                        end else if (!ovf_q) begin
                            word_d[int'(lane_q)*8 +: 8] = byte_v;
                            if (lane_q == LAST_LANE) begin
                                lane_d = '0;
                                full_d = 1'b1;
                            end else begin
                                lane_d = lane_q + 1'b1;
                            end
                        end
                    end
                end
            end
            DROP: begin
                if (!dv_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            seen5_q <= 1'b0;
            lo_q    <= '0;
            half_q  <= 1'b0;
            full_q  <= 1'b0;
            lane_q  <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            seen5_q <= seen5_d;
            lo_q    <= lo_d;
            half_q  <= half_d;
            full_q  <= full_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    assign pop = m_valid && m_ready;
    assign wr  = push && ((occ_q != OCC_MAX) || pop);

    always_ff @(posedge clk) begin
        if (wr) mem_q[wp_q] <= {push_data, push_keep, push_last, push_err};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            occ_q <= '0;
        end else begin
            if (wr)  wp_q <= wp_q + 1'b1;
            if (pop) rp_q <= rp_q + 1'b1;
            if (wr && !pop)      occ_q <= occ_q + 1'b1;
            else if (!wr && pop) occ_q <= occ_q - 1'b1;
        end
    end

    assign m_valid  = (occ_q != '0);
    assign {m_data, m_keep, m_last, m_err} = m_valid ? mem_q[rp_q] : '0;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_eth_mii_rx_framer.sv
// Scoreboard bench for eth_mii_rx_framer: directed frames, expected beats queued at issue.
module tb_eth_mii_rx_framer;
    localparam int DB   = 4;
    localparam int FD   = 4;
    localparam int MAXF = 1518;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic        e;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  mii_rxd = '0;
    logic        mii_rx_dv = 1'b0;
    logic        mii_rx_er = 1'b0;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last, m_err, m_valid;
    logic [15:0] drop_cnt;

    int    npass = 0;
    int    ntot = 0;
    int    rdy_mode = 1;
    beat_t sb[$];
    bq_t   bq;
    bit    crc_err_exp;

    always #5 clk = ~clk;

    eth_mii_rx_framer #(
        .DATA_BYTES(DB),
        .FIFO_DEPTH(FD),
        .MIN_FRAME (64),
        .MAX_FRAME (MAXF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mii_rxd  (mii_rxd),
        .mii_rx_dv(mii_rx_dv),
        .mii_rx_er(mii_rx_er),
        .m_data   (m_data),
        .m_keep   (m_keep),
        .m_last   (m_last),
        .m_err    (m_err),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .drop_cnt (drop_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] v);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ v[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic bq_t mk_frame(input int len, input int seed, input bit bad_fcs);
        bq_t q;
        logic [31:0] c;
        logic [7:0] v;
        c = '1;
        for (int i = 0; i < len - 4; i++) begin
            v = 8'(i * 13 + seed * 7 + 1);
            q.push_back(v);
            c = crc8(c, v);
        end
        c = ~c;
        if (bad_fcs) c[0] = ~c[0];
        for (int i = 0; i < 4; i++) q.push_back(c[8*i +: 8]);
        return q;
    endfunction

    task automatic expect_frame(input bq_t b, input bit drib, input bit err);
        int n, stored, nw;
        bit extra;
        beat_t x;
        n      = b.size();
        stored = (n > MAXF) ? MAXF : n;
        nw     = (stored + DB - 1) / DB;
        extra  = ((n > MAXF) || drib) && (stored % DB == 0);
        for (int w = 0; w < nw; w++) begin
            x = '0;
            for (int l = 0; l < DB; l++) begin
                if (w * DB + l < stored) begin
                    x.d[8*l +: 8] = b[w*DB + l];
                    x.k[l] = 1'b1;
                end
            end
            x.l = !extra && (w == nw - 1);
            x.e = x.l & err;
            sb.push_back(x);
        end
        if (extra) begin
            x = '0;
            x.l = 1'b1;
            x.e = err;
            sb.push_back(x);
        end
    endtask

    task automatic nib(input logic [3:0] n, input logic er);
        @(negedge clk);
        mii_rxd   = n;
        mii_rx_dv = 1'b1;
        mii_rx_er = er;
    endtask

    task automatic gap(input int n);
        @(negedge clk);
        mii_rx_dv = 1'b0;
        mii_rx_er = 1'b0;
        mii_rxd   = '0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic preamble();
        for (int i = 0; i < 15; i++) nib(4'h5, 1'b0);
        nib(4'hD, 1'b0);
    endtask

    task automatic send(input bq_t b, input int er_nib, input bit drib);
        logic [7:0] v;
        preamble();
        foreach (b[i]) begin
            v = b[i];
            nib(v[3:0], (2 * i) == er_nib);
            nib(v[7:4], (2 * i + 1) == er_nib);
        end
        if (drib) nib(4'hA, 1'b0);
        gap(12);
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while ((sb.size() != 0 || m_valid) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk(nm, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rdy_mode == 2) m_ready = 1'($urandom_range(0, 1));
            else               m_ready = (rdy_mode == 1);
        end
    end

    initial begin
        beat_t cur, prev, e;
        bit hold;
        hold = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            #2;
            cur = {m_data, m_keep, m_last, m_err};
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) chk("hold", {m_valid, cur}, {1'b1, prev});
                if (m_valid && m_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", {m_valid, cur}, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("beat", cur, e);
                    end
                end
                hold = m_valid && !m_ready;
                prev = cur;
            end
        end
    end

    initial begin
`ifdef ETH_RX_CRC_CHECK_EN
        crc_err_exp = 1'b1;
`else
        crc_err_exp = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_keep", m_keep, 0);
        chk("rst_last", m_last, 0);
        chk("rst_err", m_err, 0);
        chk("rst_drop", drop_cnt, 0);
        rst_n = 1'b1;
        gap(4);

        bq = mk_frame(64, 1, 0);   expect_frame(bq, 0, 0); send(bq, -1, 0);
        bq = mk_frame(65, 2, 0);   expect_frame(bq, 0, 0); send(bq, -1, 0);
        bq = mk_frame(60, 3, 0);   expect_frame(bq, 0, 1); send(bq, -1, 0);
        bq = mk_frame(1519, 4, 0); expect_frame(bq, 0, 1); send(bq, -1, 0);
        bq = mk_frame(64, 5, 0);   expect_frame(bq, 0, 1); send(bq, 50, 0);
        bq = mk_frame(64, 6, 0);   expect_frame(bq, 1, 1); send(bq, -1, 1);
        drain("drain_basic");

        nib(4'h5, 0); nib(4'h5, 0); nib(4'h7, 0); nib(4'h5, 0);
        for (int i = 0; i < 40; i++) nib(4'(i), 0);
        gap(12);

        bq = mk_frame(64, 7, 1); expect_frame(bq, 0, crc_err_exp); send(bq, -1, 0);
        drain("drain_crc");

        preamble();
        for (int i = 0; i < 4; i++) nib(4'(i + 3), 0);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 100; i++) nib(4'(i), 0);
        gap(12);
        bq = mk_frame(68, 8, 0); expect_frame(bq, 0, 0); send(bq, -1, 0);
        drain("drain_reset");

        rdy_mode = 2;
        bq = mk_frame(64, 9, 0);  expect_frame(bq, 0, 0); send(bq, -1, 0);
        bq = mk_frame(67, 10, 0); expect_frame(bq, 0, 0); send(bq, -1, 0);
        bq = mk_frame(70, 11, 0); expect_frame(bq, 0, 0); send(bq, -1, 0);
        rdy_mode = 1;
        drain("drain_random");

        rdy_mode = 0;
        repeat (3) @(negedge clk);
        bq = mk_frame(64, 12, 0);
        for (int w = 0; w < 3; w++)
            sb.push_back({bq[4*w+3], bq[4*w+2], bq[4*w+1], bq[4*w], 4'hF, 1'b0, 1'b0});
        sb.push_back({32'h0, 4'h0, 1'b1, 1'b1});
        send(bq, -1, 0);
        chk("ovf_valid", m_valid, 1);
        bq = mk_frame(64, 13, 0);
        send(bq, -1, 0);
        chk("drop_cnt", drop_cnt, 1);
        rdy_mode = 1;
        drain("drain_ovf");

        bq = mk_frame(72, 14, 0); expect_frame(bq, 0, 0); send(bq, -1, 0);
        drain("drain_final");

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/eth_mii_rx_framer.md
# eth_mii_rx_framer

Parametrised MII receive framer: the next-generation RX path for the Ethernet IP, running on the MII RX clock. It strips preamble and SFD, packs nibbles into `DATA_BYTES`-wide words, and validates length and optional FCS. Frames are buffered in an internal FIFO and delivered on a valid/ready stream with per-frame error status. It replaces the bare RX interface block under the Ethernet top and feeds the MAC RX side.

## Interface

**Parameters**

- `DATA_BYTES`, default 4: output word width in bytes. Legal values: 1, 2, 4, 8.
- `FIFO_DEPTH`, default 16: output FIFO depth in words. Power of 2, minimum 4.
- `MIN_FRAME`, default 64: minimum legal length in bytes, FCS included.
- `MAX_FRAME`, default 1518: maximum legal length in bytes, FCS included. Must be less than 2047.

**Ports**

- `clk`, in, 1: MII RX clock. This is the single clock for the block.
- `rst_n`, in, 1: reset. Asynchronous, active-low.
- `mii_rxd`, in, 4: MII receive nibble.
- `mii_rx_dv`, in, 1: MII data valid.
- `mii_rx_er`, in, 1: MII receive error.
- `m_data`, out, 8*DATA_BYTES: output word. Lane 0 holds the first byte of the word.
- `m_keep`, out, DATA_BYTES: byte-lane valid mask. It is contiguous from lane 0.
- `m_last`, out, 1: marks the final beat of a frame.
- `m_err`, out, 1: frame error. Meaningful only when `m_last` is high.
- `m_valid`, out, 1: output beat valid.
- `m_ready`, in, 1: sink accepts the beat.
- `drop_cnt`, out, 16: count of whole frames dropped at start because the FIFO was full. Saturates at 0xFFFF.

## Operation

- MII inputs are registered once on entry. All logic below works on the registered copies.
- Nibble order is low nibble first: byte = {second nibble, first nibble}.

**State machine: IDLE, PREAMBLE, DATA, DROP**

- **IDLE**
  - Leaves only on a rising edge of `rx_dv`, i.e. registered `rx_dv` is 1 and the previous sample was 0.
  - The previous-sample register resets to 1, so a frame already in progress when reset is released is ignored.
  - On the rising edge: if FIFO occupancy ≥ `FIFO_DEPTH`-1, go to DROP and increment `drop_cnt`. Otherwise go to PREAMBLE.
- **PREAMBLE**
  - Nibble 0x5: stay.
  - Nibble 0xD after at least one 0x5: go to DATA, with byte counter, lane pointer, error flags and CRC cleared.
  - Any other nibble, or `rx_dv` low: go to DROP, or to IDLE if `rx_dv` is low. Nothing is written to the FIFO.
- **DATA**
  - Pair nibbles into bytes and write bytes into lanes 0..DATA_BYTES-1.
  - Byte counter is 11 bits and saturating; it increments per completed byte.
  - A full word is pushed only while occupancy < `FIFO_DEPTH`-1. The last slot is reserved for the terminating beat.
  - On overflow: set the error flag, discard further bytes, keep counting, and stay in DATA.
  - Bytes beyond `MAX_FRAME` are discarded and the error flag is set.
  - `rx_er` high while `rx_dv` is high sets the error flag.
- **Frame end** (`rx_dv` sampled low while in DATA)
  - Push the terminating beat: current partial word, `m_keep` set to the lanes filled, `m_last`=1.
  - The terminating beat may have `m_keep`=0, but only if a word boundary or overflow left no bytes. In that case `m_err`=1.
  - `m_err` = OR of: `rx_er` seen, odd nibble count (dribble), length < `MIN_FRAME`, length > `MAX_FRAME`, overflow, and CRC error when enabled.
  - Next state is IDLE.
- **DROP**: wait for `rx_dv` low, then go to IDLE. No FIFO writes.
- **FIFO and stream**
  - Show-ahead FIFO drives `m_*`.
  - A beat transfers when `m_valid && m_ready`.
  - `m_data`, `m_keep`, `m_last` and `m_err` are held stable while `m_valid` is high and `m_ready` is low.
  - Simultaneous push and pop when full-minus-one is legal; occupancy is unchanged.

## Timing

- Reset values:
  - `m_valid`=0, `m_data`=0, `m_keep`=0, `m_last`=0, `m_err`=0, `drop_cnt`=0.
  - FSM in IDLE, FIFO empty.
- Reset asserted mid-frame: all state is cleared immediately and FIFO contents are lost. No partial beat is emitted after release.
- MII sample at edge k is registered at k, lane written or word pushed at k+1, and `m_valid` rises at k+2 if the FIFO was empty.
- `rx_dv` low sampled at edge k: terminating beat is written at k+1 and visible at k+2.
- The FIFO sustains one pop per cycle. The block never back-pressures MII.

## Configuration

- Macro: `ETH_RX_CRC_CHECK_EN`.
- **Defined**
  - CRC-32 runs over every byte after the SFD, FCS included.
  - Reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF, updated per byte.
  - At frame end, a residue ≠ 0xDEBB20E3 sets `m_err`.
- **Undefined**
  - No CRC logic is built; CRC never contributes to `m_err`.
- In both cases the FCS bytes are forwarded in the data stream.

## Test plan

- **Legal 64-byte frame, `DATA_BYTES`=4, `m_ready`=1:** 7×0x55 + 0xD5 preamble/SFD, then a valid FCS. Required: 16 beats, all `m_keep`=0xF; last beat has `m_last`=1, `m_err`=0. First `m_valid` appears 2 cycles after the 8th nibble of the data.
- **65-byte frame:** required: 17 beats; the final beat has `m_keep`=0x1, `m_last`=1.
- **Short and long frames:** 60-byte frame → `m_err`=1 on the last beat. 1519-byte frame → 380 beats, with `m_err`=1.
- **`m_ready`=0 throughout, `FIFO_DEPTH`=4, 64-byte frame:** 3 words buffered, then overflow. Required: terminating beat pushed with `m_err`=1. A following frame starting while occupancy is 4 → `drop_cnt`=1 and no beats emitted for it.
- **Error conditions:**
  - `rx_er` pulsed mid-frame → `m_err`=1.
  - 129-nibble data phase → `m_err`=1 (dribble).
  - Preamble 0x55 0x57 → no output (DROP).
  - With `ETH_RX_CRC_CHECK_EN`, one flipped FCS bit → `m_err`=1.
- **Reset and stability:**
  - `rst_n` low for 1 cycle mid-frame with `rx_dv` held high → no output for that frame; the next frame is received cleanly.
  - `m_ready` toggled randomly → beat order and data match the reference byte stream exactly.
